// File: rtl/param_fifo.sv
// Parametrised first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module param_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = 3,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Flush,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     Enqueue,
    input  logic                     Dequeue,
    output logic [WIDTH-1:0]         DataOut,
    output logic                     Empty,
    output logic                     Full,
    output logic                     AlmostEmpty,
    output logic                     AlmostFull,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic                     Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               cnt;
    logic                        ovf, unf;
    logic                        push_ok, pop_ok;

    // Status is a pure function of registered state, so request inputs never
    // reach the status outputs combinationally.
    assign Empty       = (cnt == '0);
    assign Full        = (cnt == CW'(DEPTH));
    assign AlmostEmpty = (cnt <= CW'(AEMPTY_LVL));
    assign AlmostFull  = (cnt >= CW'(AFULL_LVL));
    assign Count       = cnt;
    assign Overflow    = ovf;
    assign Underflow   = unf;
    assign DataOut     = Empty ? '0 : mem[rd_ptr];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok = Enqueue & (~Full | Dequeue);
    assign pop_ok  = Dequeue & ~Empty;

    always_ff @(posedge Clk) begin
        if (push_ok && !Flush) mem[wr_ptr] <= DataIn;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (Enqueue && Full && !Dequeue) ovf <= 1'b1;
            if (Dequeue && Empty)            unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: stimulus queues expected words, a negedge
// monitor checks every word leaving the FIFO against that queue.
module tb_param_fifo;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Flush = 1'b0;
    logic [15:0] DataIn = '0;
    logic        Enqueue = 1'b0;
    logic        Dequeue = 1'b0;
    logic [15:0] DataOut;
    logic        Empty, Full, AlmostEmpty, AlmostFull;
    logic [2:0]  Count;
    logic        Overflow, Underflow;

    int errors = 0;
    int checks = 0;
    int mcnt   = 0;
    logic [15:0] sb[$];

    param_fifo #(.WIDTH(16), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .DataIn(DataIn),
        .Enqueue(Enqueue), .Dequeue(Dequeue), .DataOut(DataOut),
        .Empty(Empty), .Full(Full), .AlmostEmpty(AlmostEmpty),
        .AlmostFull(AlmostFull), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Words leave on the edge after the negedge where a pop is presented.
    always @(negedge Clk) begin
        if (Rst && !Flush && Dequeue && !Empty) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", DataOut);
            end else begin
                chk("pop_data", {16'h0, DataOut}, {16'h0, sb.pop_front()});
            end
        end
    end

    task automatic step(input logic enq, input logic deq, input logic [15:0] d);
        bit pu, po;
        Enqueue = enq;
        Dequeue = deq;
        DataIn  = d;
        pu = enq && (mcnt < 4 || deq);
        po = deq && (mcnt > 0);
        if (pu) sb.push_back(d);
        mcnt = mcnt + int'(pu) - int'(po);
        @(posedge Clk); #1;
        Enqueue = 1'b0;
        Dequeue = 1'b0;
    endtask

    task automatic flush();
        Flush   = 1'b1;
        Enqueue = 1'b1;
        Dequeue = 1'b1;
        DataIn  = 16'hDEAD;
        sb.delete();
        mcnt = 0;
        @(posedge Clk); #1;
        Flush   = 1'b0;
        Enqueue = 1'b0;
        Dequeue = 1'b0;
    endtask

    task automatic fill4();
        step(1, 0, 16'h1111);
        step(1, 0, 16'h2222);
        step(1, 0, 16'h3333);
        step(1, 0, 16'h4444);
    endtask

    task automatic drain4();
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ae_t[5];
        bit af_t[5];
        ae_t = '{1, 1, 0, 0, 0};
        af_t = '{0, 0, 0, 1, 1};

        #2;
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_ae", AlmostEmpty, 1);
        chk("rst_af", AlmostFull, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_unf", Underflow, 0);
        chk("rst_dout", DataOut, 0);
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;

        // 1: basic ordering
        fill4();
        chk("t1_full", Full, 1);
        chk("t1_count4", Count, 4);
        chk("t1_head", DataOut, 16'h1111);
        drain4();
        chk("t1_count0", Count, 0);
        chk("t1_empty", Empty, 1);
        chk("t1_ovf", Overflow, 0);
        chk("t1_unf", Underflow, 0);

        // 2: overflow, underflow, flush priority
        fill4();
        step(1, 0, 16'h5555);
        chk("t2_ovf", Overflow, 1);
        chk("t2_count", Count, 4);
        chk("t2_head", DataOut, 16'h1111);
        drain4();
        chk("t2_unf_pre", Underflow, 0);
        step(0, 1, 16'h0);
        chk("t2_unf", Underflow, 1);
        chk("t2_ovf_sticky", Overflow, 1);
        chk("t2_count0", Count, 0);
        flush();
        chk("t2_fl_ovf", Overflow, 0);
        chk("t2_fl_unf", Underflow, 0);
        chk("t2_fl_count", Count, 0);
        chk("t2_fl_empty", Empty, 1);

        // 3: simultaneous push/pop while full, wrap-around
        fill4();
        step(1, 1, 16'hAAAA);
        chk("t3_count", Count, 4);
        chk("t3_full", Full, 1);
        chk("t3_head", DataOut, 16'h2222);
        for (int i = 0; i < 10; i++) step(1, 1, 16'hC000 + 16'(i));
        chk("t3_count_wrap", Count, 4);
        chk("t3_head_wrap", DataOut, 16'hC006);
        drain4();
        chk("t3_empty", Empty, 1);
        chk("t3_ovf", Overflow, 0);
        chk("t3_unf", Underflow, 0);

        // 4: simultaneous push/pop while empty
        step(1, 1, 16'hBEEF);
        chk("t4_count", Count, 1);
        chk("t4_dout", DataOut, 16'hBEEF);
        chk("t4_unf", Underflow, 1);
        step(0, 1, 16'h0);
        flush();

        // 5: thresholds
        for (int i = 0; i < 5; i++) begin
            chk("t5_count", Count, i);
            chk("t5_ae", AlmostEmpty, ae_t[i]);
            chk("t5_af", AlmostFull, af_t[i]);
            if (i < 4) step(1, 0, 16'h0100 + 16'(i));
        end
        drain4();
        flush();

        // 6: async reset mid-operation
        step(1, 0, 16'h6661);
        step(1, 0, 16'h6662);
        step(1, 0, 16'h6663);
        chk("t6_count3", Count, 3);
        #1 Rst = 1'b0;
        #1;
        chk("t6_rst_count", Count, 0);
        chk("t6_rst_empty", Empty, 1);
        chk("t6_rst_dout", DataOut, 0);
        chk("t6_rst_ae", AlmostEmpty, 1);
        sb.delete();
        mcnt = 0;
        #1 Rst = 1'b1;
        @(posedge Clk); #1;
        step(1, 0, 16'h7777);
        chk("t6_dout", DataOut, 16'h7777);
        chk("t6_count1", Count, 1);
        step(0, 1, 16'h0);
        chk("t6_empty", Empty, 1);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
